// File: rtl/prf_pkg.sv
// Physical register file constants and types, shared with rename, router and ROB.
package prf_pkg;

   localparam int unsigned PRN_BITS     = 6;
   localparam int unsigned MAX_OPERANDS = 3;
   localparam int unsigned DATA_W       = 64;

   typedef logic [PRN_BITS-1:0] prn_t;
   typedef logic [DATA_W-1:0]   word_t;

endpackage

// File: rtl/prf_read_lane.sv
// One combinational read lane of the physical register file.
// With PRF_BYPASS_EN defined, same-cycle write data is forwarded to the lane.
module prf_read_lane
   import prf_pkg::*;
#(
`ifdef PRF_BYPASS_EN
   parameter int unsigned W_PORTS      = 4,
   parameter int unsigned MAX_OPERANDS = prf_pkg::MAX_OPERANDS,
`endif
   parameter int unsigned PRN_BITS     = prf_pkg::PRN_BITS,
   parameter int unsigned DATA_W       = prf_pkg::DATA_W
) (
   input  logic                ren,
   input  logic [PRN_BITS-1:0] rprn,
   input  logic [DATA_W-1:0]   regs [2**PRN_BITS],
`ifdef PRF_BYPASS_EN
   input  logic                wen   [W_PORTS][MAX_OPERANDS],
   input  logic [PRN_BITS-1:0] wprn  [W_PORTS][MAX_OPERANDS],
   input  logic [DATA_W-1:0]   wdata [W_PORTS][MAX_OPERANDS],
`endif
   output logic [DATA_W-1:0]   rdata
);

   always_comb begin
      rdata = '0;
      if (ren) begin
         rdata = regs[rprn];
`ifdef PRF_BYPASS_EN
         // Ascending scan: the highest flat write index that matches wins.
         for (int unsigned p = 0; p < W_PORTS; p++) begin
            for (int unsigned o = 0; o < MAX_OPERANDS; o++) begin
               if (wen[p][o] && (wprn[p][o] == rprn)) begin
                  rdata = wdata[p][o];
               end
            end
         end
`endif
      end
   end

endmodule

// File: rtl/phys_reg_file.sv
// Multi-ported physical register file: combinational reads, clocked prioritized writes.
// Optional same-cycle write-to-read forwarding under PRF_BYPASS_EN.
module phys_reg_file
   import prf_pkg::*;
#(
   parameter int unsigned R_PORTS      = 4,
   parameter int unsigned W_PORTS      = 4,
   parameter int unsigned MAX_OPERANDS = prf_pkg::MAX_OPERANDS,
   parameter int unsigned PRN_BITS     = prf_pkg::PRN_BITS,
   parameter int unsigned DATA_W       = prf_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_ren   [R_PORTS][MAX_OPERANDS],
   input  logic [PRN_BITS-1:0] op_rprn  [R_PORTS][MAX_OPERANDS],
   output logic [DATA_W-1:0]   op_rdata [R_PORTS][MAX_OPERANDS],
   input  logic                op_wen   [W_PORTS][MAX_OPERANDS],
   input  logic [PRN_BITS-1:0] op_wprn  [W_PORTS][MAX_OPERANDS],
   input  logic [DATA_W-1:0]   op_wdata [W_PORTS][MAX_OPERANDS]
);

   localparam int unsigned NumPregs = 2**PRN_BITS;

   logic [DATA_W-1:0] regs [NumPregs];

   // Later non-blocking assignments override earlier ones, so the highest
   // flat lane index wins on a same-PRN collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NumPregs; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < W_PORTS; p++) begin
            for (int unsigned o = 0; o < MAX_OPERANDS; o++) begin
               if (op_wen[p][o]) begin
                  regs[op_wprn[p][o]] <= op_wdata[p][o];
               end
            end
         end
      end
   end

   for (genvar p = 0; p < R_PORTS; p++) begin : g_rport
      for (genvar o = 0; o < MAX_OPERANDS; o++) begin : g_lane
         prf_read_lane #(
`ifdef PRF_BYPASS_EN
            .W_PORTS      (W_PORTS),
            .MAX_OPERANDS (MAX_OPERANDS),
`endif
            .PRN_BITS     (PRN_BITS),
            .DATA_W       (DATA_W)
         ) u_lane (
            .ren   (op_ren[p][o]),
            .rprn  (op_rprn[p][o]),
            .regs  (regs),
`ifdef PRF_BYPASS_EN
            .wen   (op_wen),
            .wprn  (op_wprn),
            .wdata (op_wdata),
`endif
            .rdata (op_rdata[p][o])
         );
      end
   end

endmodule

// File: tb/tb_phys_reg_file.sv
// Scoreboard bench for phys_reg_file; expectations follow PRF_BYPASS_EN when defined.
module tb_phys_reg_file;

   localparam int RP = 4;
   localparam int WP = 4;
   localparam int MO = 3;
   localparam int PB = 6;
   localparam int DW = 64;

   logic          clk;
   logic          rst;
   logic          ren   [RP][MO];
   logic [PB-1:0] rprn  [RP][MO];
   logic [DW-1:0] rdata [RP][MO];
   logic          wen   [WP][MO];
   logic [PB-1:0] wprn  [WP][MO];
   logic [DW-1:0] wdata [WP][MO];

   int checks = 0;
   int errors = 0;

   string         name_q [$];
   int            p_q    [$];
   int            o_q    [$];
   logic [DW-1:0] exp_q  [$];
   event          sample_ev;

   phys_reg_file #(
      .R_PORTS      (RP),
      .W_PORTS      (WP),
      .MAX_OPERANDS (MO),
      .PRN_BITS     (PB),
      .DATA_W       (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .op_ren   (ren),
      .op_rprn  (rprn),
      .op_rdata (rdata),
      .op_wen   (wen),
      .op_wprn  (wprn),
      .op_wdata (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compares every queued expectation at the sampling point.
   initial begin
      forever begin
         @(negedge clk or sample_ev);
         while (exp_q.size() > 0) begin
            string         nm;
            int            p;
            int            o;
            logic [DW-1:0] e;
            nm = name_q.pop_front();
            p  = p_q.pop_front();
            o  = o_q.pop_front();
            e  = exp_q.pop_front();
            checks++;
            if (rdata[p][o] !== e) begin
               errors++;
               $display("FAIL %s lane %0d.%0d got %h expected %h", nm, p, o, rdata[p][o], e);
            end
         end
      end
   end

   task automatic clr();
      for (int p = 0; p < RP; p++) begin
         for (int o = 0; o < MO; o++) begin
            ren[p][o]  = 1'b0;
            rprn[p][o] = '0;
         end
      end
      for (int p = 0; p < WP; p++) begin
         for (int o = 0; o < MO; o++) begin
            wen[p][o]   = 1'b0;
            wprn[p][o]  = '0;
            wdata[p][o] = '0;
         end
      end
   endtask

   task automatic rd(input int p, input int o, input logic [PB-1:0] prn);
      ren[p][o]  = 1'b1;
      rprn[p][o] = prn;
   endtask

   task automatic wr(input int p, input int o, input logic [PB-1:0] prn,
                     input logic [DW-1:0] d);
      wen[p][o]   = 1'b1;
      wprn[p][o]  = prn;
      wdata[p][o] = d;
   endtask

   task automatic expect_rd(input string nm, input int p, input int o, input logic [DW-1:0] v);
      name_q.push_back(nm);
      p_q.push_back(p);
      o_q.push_back(o);
      exp_q.push_back(v);
   endtask

   // Checks fire at the negedge; writes commit at the following posedge.
   task automatic cycle();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] full_val(input int f);
      return {32'hC0DE0000 + 32'(f), 32'h1000 * 32'(f + 1)};
   endfunction

   initial begin
      rst = 1'b0;
      clr();
      // Reset state
      rd(0, 0, 6'd0);
      rd(0, 1, 6'd17);
      rd(0, 2, 6'd63);
      expect_rd("reset_prn0", 0, 0, 64'h0);
      expect_rd("reset_prn17", 0, 1, 64'h0);
      expect_rd("reset_prn63", 0, 2, 64'h0);
      cycle();

      // First writes right after release
      rst = 1'b1;
      clr();
      wr(0, 0, 6'd0, 64'h1234);
      wr(1, 1, 6'd17, 64'h5555);
      wr(3, 2, 6'd63, 64'hFFFF0000FFFF0000);
      cycle();
      clr();
      rd(0, 0, 6'd0);
      rd(0, 1, 6'd17);
      rd(0, 2, 6'd63);
      expect_rd("preload_prn0", 0, 0, 64'h1234);
      expect_rd("preload_prn17", 0, 1, 64'h5555);
      expect_rd("preload_prn63", 0, 2, 64'hFFFF0000FFFF0000);
      @(negedge clk);
      #1;

      // Asynchronous reset mid-cycle with a write pending
      wr(1, 1, 6'd17, 64'h77);
      rst = 1'b0;
      #1;
      expect_rd("async_rst_prn0", 0, 0, 64'h0);
      expect_rd("async_rst_prn17", 0, 1, 64'h0);
      expect_rd("async_rst_prn63", 0, 2, 64'h0);
      -> sample_ev;
      @(posedge clk);
      #1;
      rst = 1'b1;
      wen[1][1] = 1'b0;
      expect_rd("post_rst_prn0", 0, 0, 64'h0);
      expect_rd("post_rst_prn17", 0, 1, 64'h0);
      expect_rd("post_rst_prn63", 0, 2, 64'h0);
      cycle();

      // Basic write / read
      clr();
      wr(2, 1, 6'd5, 64'hDEADBEEF00000001);
      cycle();
      clr();
      rd(0, 0, 6'd5);
      rd(1, 2, 6'd5);
      rd(3, 1, 6'd5);
      rprn[2][0] = 6'd5;
      expect_rd("basic_p0o0", 0, 0, 64'hDEADBEEF00000001);
      expect_rd("basic_p1o2", 1, 2, 64'hDEADBEEF00000001);
      expect_rd("basic_p3o1", 3, 1, 64'hDEADBEEF00000001);
      expect_rd("basic_ren0", 2, 0, 64'h0);
      rd(1, 0, 6'd40);
      expect_rd("unwritten_prn40", 1, 0, 64'h0);
      cycle();

      // Collision: highest flat index wins
      clr();
      wr(0, 0, 6'd9, 64'h11);
      wr(3, 2, 6'd9, 64'h22);
      rd(1, 1, 6'd9);
`ifdef PRF_BYPASS_EN
      expect_rd("collision_fwd", 1, 1, 64'h22);
`else
      expect_rd("collision_fwd", 1, 1, 64'h0);
`endif
      cycle();
      clr();
      rd(2, 2, 6'd9);
      expect_rd("collision_stored", 2, 2, 64'h22);
      cycle();

      // Same-cycle read of a write
      clr();
      wr(0, 1, 6'd12, 64'hAA);
      cycle();
      clr();
      wr(1, 2, 6'd12, 64'hBB);
      rd(2, 1, 6'd12);
`ifdef PRF_BYPASS_EN
      expect_rd("same_cycle_rd", 2, 1, 64'hBB);
`else
      expect_rd("same_cycle_rd", 2, 1, 64'hAA);
`endif
      cycle();
      clr();
      rd(2, 1, 6'd12);
      expect_rd("next_cycle_rd", 2, 1, 64'hBB);
      cycle();

      // Full port load, read back in reversed lane order
      clr();
      for (int f = 0; f < WP * MO; f++) begin
         wr(f / MO, f % MO, 6'(20 + f), full_val(f));
      end
      cycle();
      clr();
      for (int f = 0; f < RP * MO; f++) begin
         rd(f / MO, f % MO, 6'(20 + (11 - f)));
         expect_rd($sformatf("full_load_%0d", f), f / MO, f % MO, full_val(11 - f));
      end
      cycle();

      // Disabled write lanes carry addresses and data but must be ignored
      clr();
      wprn[0][0] = 6'd5;  wdata[0][0] = 64'hBAD0;
      wprn[2][1] = 6'd9;  wdata[2][1] = 64'hBAD1;
      wprn[3][2] = 6'd12; wdata[3][2] = 64'hBAD2;
      rd(0, 0, 6'd5);
      expect_rd("ignored_same_cycle", 0, 0, 64'hDEADBEEF00000001);
      cycle();
      clr();
      rd(0, 0, 6'd5);
      rd(1, 1, 6'd9);
      rd(2, 2, 6'd12);
      expect_rd("ignored_prn5", 0, 0, 64'hDEADBEEF00000001);
      expect_rd("ignored_prn9", 1, 1, 64'h22);
      expect_rd("ignored_prn12", 2, 2, 64'hBB);
      cycle();

      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
